// File: rtl/lights_out_grid.sv
// Lights Out core: NxN lamp field, cross-pattern presses, LFSR puzzle scrambler, move counter.
// Define LIGHTS_OUT_WRAP_EN for a toroidal board (neighbours wrap across edges).
module lights_out_grid #(
  parameter int          N        = 3,
  parameter int          CNT_W    = 8,
  parameter int          SCRAMBLE = 16,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [N*N-1:0]     btn,
  input  logic               new_game,
  output logic [N*N-1:0]     field,
  output logic [CNT_W-1:0]   moves,
  output logic               busy,
  output logic               solved
);

  localparam int CELLS = N * N;
  localparam int IDX_W = $clog2(CELLS);
  localparam int TBL   = 1 << IDX_W;
  localparam int SC_W  = (SCRAMBLE > 0) ? $clog2(SCRAMBLE + 1) : 1;
  localparam logic [SC_W-1:0]  SC_LOAD = SC_W'(SCRAMBLE);
  localparam logic [IDX_W:0]   CELLS_V = (IDX_W + 1)'(CELLS);

  typedef enum logic [1:0] {S_SCR, S_PLAY, S_WON} state_t;
  localparam state_t RST_STATE = (SCRAMBLE > 0) ? S_SCR : S_PLAY;

  state_t             state, state_nxt;
  logic [CELLS-1:0]   field_nxt, prev_btn, edges;
  logic [CNT_W-1:0]   moves_nxt;
  logic [SC_W-1:0]    cnt, cnt_nxt;
  logic [15:0]        lfsr, lfsr_nxt;
  logic [IDX_W-1:0]   cand, press_idx;
  logic               cand_ok;

  // XOR parity so coincident neighbours on a tiny torus cancel out.
  function automatic logic [CELLS-1:0] pattern(input int i);
    logic [CELLS-1:0] m;
    int r, c, rj, cj;
    logic b;
    m = '0;
    r = i / N;
    c = i % N;
    for (int j = 0; j < CELLS; j++) begin
      rj = j / N;
      cj = j % N;
      b  = (j == i);
`ifdef LIGHTS_OUT_WRAP_EN
      b ^= (cj == c) && (rj == (r + 1) % N);
      b ^= (cj == c) && (rj == (r + N - 1) % N);
      b ^= (rj == r) && (cj == (c + 1) % N);
      b ^= (rj == r) && (cj == (c + N - 1) % N);
`else
      b ^= (cj == c) && (rj == r + 1);
      b ^= (cj == c) && (rj == r - 1);
      b ^= (rj == r) && (cj == c + 1);
      b ^= (rj == r) && (cj == c - 1);
`endif
      if (b) m = m | (CELLS'(1) << j);
    end
    return m;
  endfunction

  // Table padded to a power of two so any LFSR index is a legal lookup.
  logic [CELLS-1:0] pat_tbl [TBL];
  for (genvar g = 0; g < TBL; g++) begin : g_pat
    assign pat_tbl[g] = (g < CELLS) ? pattern(g) : '0;
  end

  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign cand     = lfsr[IDX_W-1:0];
  assign cand_ok  = {1'b0, cand} < CELLS_V;
  assign edges    = btn & ~prev_btn;

  always_comb begin
    press_idx = '0;
    for (int i = CELLS - 1; i >= 0; i--)
      if (edges[i]) press_idx = IDX_W'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RST_STATE;
      field    <= '0;
      moves    <= '0;
      cnt      <= SC_LOAD;
      lfsr     <= SEED;
      prev_btn <= '0;
    end else if (ena) begin
      state    <= state_nxt;
      field    <= field_nxt;
      moves    <= moves_nxt;
      cnt      <= cnt_nxt;
      lfsr     <= lfsr_nxt;
      prev_btn <= btn;
    end
  end

  always_comb begin
    state_nxt = state;
    field_nxt = field;
    moves_nxt = moves;
    cnt_nxt   = cnt;
    if (new_game) begin
      moves_nxt = '0;
      cnt_nxt   = SC_LOAD;
      if (SCRAMBLE > 0) state_nxt = S_SCR;
      else begin
        state_nxt = S_PLAY;
        field_nxt = '0;
      end
    end else begin
      case (state)
        S_SCR: begin
          // A scramble that lands back on the solved board is simply rerun.
          if (cnt == '0) begin
            if (field == '0) cnt_nxt = SC_LOAD;
            else             state_nxt = S_PLAY;
          end else if (cand_ok) begin
            field_nxt = field ^ pat_tbl[cand];
            cnt_nxt   = cnt - SC_W'(1);
          end
        end
        S_PLAY: begin
          if (|edges) begin
            field_nxt = field ^ pat_tbl[press_idx];
            if (moves != '1) moves_nxt = moves + CNT_W'(1);
            if (field_nxt == '0) state_nxt = S_WON;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == S_SCR);
  assign solved = (state == S_WON);

endmodule

// File: tb/tb_lights_out_grid.sv
// Bench for lights_out_grid: three 3x3 instances (no-scramble, default scramble, 2-bit counter)
// checked against a rule-level model, directed steps followed by a randomized phase.
module tb_lights_out_grid;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [8:0] btn = '0, btn_b = '0;
  logic ng = 1'b0, ng_b = 1'b0;

  logic [8:0] fa, fb, fc;
  logic [7:0] ma, mb;
  logic [1:0] mc;
  logic busy_a, busy_b, busy_c, solved_a, solved_b, solved_c;

  lights_out_grid #(.N(3), .CNT_W(8), .SCRAMBLE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn(btn), .new_game(ng),
    .field(fa), .moves(ma), .busy(busy_a), .solved(solved_a));

  lights_out_grid dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn(btn_b), .new_game(ng_b),
    .field(fb), .moves(mb), .busy(busy_b), .solved(solved_b));

  lights_out_grid #(.N(3), .CNT_W(2), .SCRAMBLE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn(btn), .new_game(ng),
    .field(fc), .moves(mc), .busy(busy_c), .solved(solved_c));

  always #5 clk = ~clk;

  int tests = 0, failed = 0;

  // Reference for the two no-scramble instances (they share inputs).
  logic [8:0] m_field = '0, m_prev = '0;
  int m_ma = 0, m_mc = 0;
  bit m_won = 1'b0;

  function automatic logic [8:0] pat(int i);
    int r = i / 3;
    int c = i % 3;
    logic [8:0] m = 9'(1) << i;
`ifdef LIGHTS_OUT_WRAP_EN
    m ^= 9'(1) << (((r + 2) % 3) * 3 + c);
    m ^= 9'(1) << (((r + 1) % 3) * 3 + c);
    m ^= 9'(1) << (r * 3 + (c + 2) % 3);
    m ^= 9'(1) << (r * 3 + (c + 1) % 3);
`else
    if (r > 0) m ^= 9'(1) << (i - 3);
    if (r < 2) m ^= 9'(1) << (i + 3);
    if (c > 0) m ^= 9'(1) << (i - 1);
    if (c < 2) m ^= 9'(1) << (i + 1);
`endif
    return m;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [8:0] e;
    bit found;
    @(posedge clk);
    if (!rst_n) begin
      m_field = '0; m_prev = '0; m_ma = 0; m_mc = 0; m_won = 1'b0;
    end else if (ena) begin
      if (ng) begin
        m_field = '0; m_ma = 0; m_mc = 0; m_won = 1'b0;
      end else if (!m_won) begin
        e = btn & ~m_prev;
        found = 1'b0;
        for (int i = 0; i < 9; i++)
          if (e[i] && !found) begin
            found = 1'b1;
            m_field ^= pat(i);
            m_ma = (m_ma < 255) ? m_ma + 1 : 255;
            m_mc = (m_mc < 3) ? m_mc + 1 : 3;
            m_won = (m_field == 9'd0);
          end
      end
      m_prev = btn;
    end
    #1;
    chk("a_field", 32'(fa), 32'(m_field));
    chk("a_moves", 32'(ma), 32'(m_ma));
    chk("a_solved", 32'(solved_a), 32'(m_won));
    chk("a_busy", 32'(busy_a), 32'd0);
    chk("c_field", 32'(fc), 32'(m_field));
    chk("c_moves", 32'(mc), 32'(m_mc));
  endtask

  task automatic wait_b_idle(output int n);
    n = 0;
    while (busy_b === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("b_busy_timeout", 32'(busy_b), 32'd0);
  endtask

  task automatic press(int i);
    btn = 9'(1) << i; tick();
    btn = '0; tick();
  endtask

  int n;
  logic [8:0] f0, exp_f;

  initial begin
    // Reset state.
    tick(); tick();
    chk("b_rst_busy", 32'(busy_b), 32'd1);
    chk("b_rst_field", 32'(fb), 32'd0);
    chk("b_rst_moves", 32'(mb), 32'd0);
    chk("b_rst_solved", 32'(solved_b), 32'd0);
    rst_n = 1'b1;

    // Default scramble: busy at least 16 cycles, then a nonzero board.
    wait_b_idle(n);
    chk("b_busy_len_ge16", 32'(n >= 16), 32'd1);
    chk("b_field_nonzero", 32'(fb != 9'd0), 32'd1);
    chk("b_moves_zero", 32'(mb), 32'd0);

    f0 = fb;
    btn_b = 9'h010; tick();
    exp_f = f0 ^ pat(4);
    chk("b_press_field", 32'(fb), 32'(exp_f));
    chk("b_press_moves", 32'(mb), 32'd1);
    chk("b_press_solved", 32'(solved_b), 32'(exp_f == 9'd0));
    btn_b = '0; tick();

    ng_b = 1'b1; tick(); ng_b = 1'b0;
    chk("b_ng_moves", 32'(mb), 32'd0);
    chk("b_ng_busy", 32'(busy_b), 32'd1);
    chk("b_ng_solved", 32'(solved_b), 32'd0);
    wait_b_idle(n);
    chk("b_ng_field_nonzero", 32'(fb != 9'd0), 32'd1);

    // Centre press twice solves the empty board.
    btn = 9'h010; tick();
    chk("a_c4_field", 32'(fa), 32'h0BA);
    btn = '0; tick();
    btn = 9'h010; tick();
    chk("a_c4_solve_field", 32'(fa), 32'h000);
    chk("a_c4_solve_moves", 32'(ma), 32'd2);
    chk("a_c4_solved", 32'(solved_a), 32'd1);
    btn = '0; tick();
    btn = 9'h024; tick();
    chk("a_won_hold_field", 32'(fa), 32'h000);
    chk("a_won_hold_moves", 32'(ma), 32'd2);
    btn = '0; ng = 1'b1; tick(); ng = 1'b0;
    chk("a_ng_solved", 32'(solved_a), 32'd0);

    // Corner press, then held for 10 cycles.
    btn = 9'h001; tick();
`ifdef LIGHTS_OUT_WRAP_EN
    chk("a_c0_field", 32'(fa), 32'h04F);
`else
    chk("a_c0_field", 32'(fa), 32'h00B);
`endif
    repeat (10) tick();
    chk("a_hold_moves", 32'(ma), 32'd1);
    btn = '0; tick();

    // Simultaneous edges: lowest index wins.
    exp_f = m_field ^ pat(2);
    btn = 9'h024; tick();
    chk("a_simul_field", 32'(fa), 32'(exp_f));
    chk("a_simul_moves", 32'(ma), 32'd2);
    btn = '0; tick();

    // Counter saturation on the 2-bit instance.
    ng = 1'b1; tick(); ng = 1'b0;
    press(0); press(1); press(2); press(0); press(1);
    chk("c_sat_moves", 32'(mc), 32'd3);
    chk("a_nosat_moves", 32'(ma), 32'd5);

    // Randomized presses, enable gaps and occasional new games.
    for (int k = 0; k < 400; k++) begin
      ena = ($urandom_range(9) != 0);
      ng  = ($urandom_range(49) == 0);
      btn = ($urandom_range(3) == 0) ? 9'($urandom) : (btn & 9'($urandom));
      tick();
    end
    ena = 1'b1; ng = 1'b0; btn = '0; tick();

    // Reset in the middle of a scramble.
    ng_b = 1'b1; tick(); ng_b = 1'b0;
    tick(); tick();
    chk("b_mid_busy", 32'(busy_b), 32'd1);
    rst_n = 1'b0; tick();
    chk("b_mrst_busy", 32'(busy_b), 32'd1);
    chk("b_mrst_field", 32'(fb), 32'd0);
    chk("b_mrst_moves", 32'(mb), 32'd0);
    chk("b_mrst_solved", 32'(solved_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/lights_out_grid.md
# lights_out_grid

Parametrised Lights Out game core: an N×N lamp field with per-cell press inputs and a cross toggle pattern. Generates solvable puzzles from an internal LFSR, counts moves and flags a solved board. Sits behind the top-level pin wrapper, which maps `btn` and `field` onto `ui_in`/`uio_in` and `uo_out`/`uio_out`.

## Interface
Parameters:
- `N`, 3: grid side, 2..8; cells = N*N, index = row*N + col.
- `CNT_W`, 8: width of the move counter.
- `SCRAMBLE`, 16: random presses applied per new game; 0 disables scrambling.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  clock enable; low freezes all state, including edge detectors. Reset still applies.
- `btn`  in  N*N  press levels, already synchronised; one bit per cell.
- `new_game`  in  1  level; sampled high starts a new puzzle.
- `field`  out  N*N  lamp state, 1 = lit.
- `moves`  out  CNT_W  accepted presses since the last new game; saturates at all-ones.
- `busy`  out  1  high while scrambling.
- `solved`  out  1  high in WON.

## Operation
- Reset values: `field`=0, `moves`=0, `solved`=0, LFSR=`SEED`, previous-`btn` register=0, state=SCRAMBLE. `busy`=1 when SCRAMBLE>0; otherwise the core goes straight to PLAY with `busy`=0.
- States: SCRAMBLE, PLAY, WON.
- Press pattern at cell i: toggle cell i and its orthogonal neighbours. Edge neighbours that would fall outside the grid are dropped (see Configuration for the alternative).
- SCRAMBLE:
  - LFSR: 16-bit Galois, taps 16,14,13,11. It advances one step every enabled cycle in every state.
  - Candidate index = low ceil(log2(N*N)) bits of the LFSR.
  - If index < N*N: apply the press pattern and decrement the remaining count.
  - Otherwise: skip the cycle; the count is unchanged.
  - When the count reaches 0 and `field`==0, reload the count and repeat the scramble.
  - When the count reaches 0 and `field`!=0, go to PLAY.
  - Buttons are ignored during SCRAMBLE.
- PLAY:
  - Rising edge on `btn[i]` = current 1 and previous 0.
  - Only the lowest-index edge in a cycle is accepted. The other edges in that cycle are consumed and discarded.
  - An accepted press applies the pattern and increments `moves` (saturating).
  - If the next `field` == 0, go to WON.
- WON: `field` and `moves` hold and all presses are ignored. Only `new_game` or reset leaves this state.
- `new_game` high in any state:
  - next state is SCRAMBLE, `moves`=0, `solved`=0, count reloaded;
  - `field` is kept and scrambled further;
  - `new_game` has priority over a same-cycle press;
  - with SCRAMBLE=0 the next state is PLAY and `field` is cleared.
- Scrambling applies only press patterns, so every generated puzzle is solvable.

## Timing
- Press latency: an edge sampled at clock edge k updates `field` and `moves` as registered outputs after edge k. `solved` rises on the same edge as the winning `field` update.
- Scramble duration: at least SCRAMBLE enabled cycles, plus one cycle per skipped index, plus any repeats. `busy` falls on the same edge as the entry to PLAY.
- `new_game` takes effect on the edge at which it is sampled.
- A held `btn` produces one press only. Release and re-press is needed for another.
- A button held through SCRAMBLE does not register as a press in PLAY, because the previous-`btn` register updates in every state.
- `ena` low: no state change and no edge capture. The edge detector resumes from its frozen previous value.

## Configuration
- `LIGHTS_OUT_WRAP_EN` defined: toroidal board. Neighbours wrap across edges, so every cell toggles exactly 5 cells (for N=2, duplicate neighbours cancel by XOR).
- Undefined: edge neighbours are dropped. Corners toggle 3 cells, edge cells 4, interior cells 5.

## Test plan
- N=3, SCRAMBLE=0, wrap off: reset, pulse `btn[4]` -> `field`=9'h0BA, `moves`=1, `solved`=0. Pulse `btn[4]` again -> `field`=0, `moves`=2, `solved`=1.
- N=3, SCRAMBLE=0, wrap off: pulse `btn[0]` -> `field`=9'h00B. Hold `btn[0]` 10 cycles -> exactly one toggle.
- N=3, SCRAMBLE=0, `LIGHTS_OUT_WRAP_EN` defined: pulse `btn[0]` -> `field`=9'h04F.
- Simultaneous rising edges on `btn[2]` and `btn[5]` -> only the cell-2 pattern is applied, `moves`+1. In WON, presses leave `field` and `moves` unchanged.
- Default parameters: reset -> `busy` high at least 16 cycles, then `field`!=0 and `busy`=0. Pulse `new_game` mid-game -> `moves`=0, `busy` rises on the next edge.
- CNT_W=2, SCRAMBLE=0: 5 presses on non-solving cells -> `moves` saturates at 3. Assert `rst_n` low mid-scramble -> all outputs at their reset values on the next edge.
